// File: rtl/ram_bank_loader.sv
// Stream-to-RAM write sequencer: accepts a programmed number of words from a
// valid/ready stream and issues one registered ram_bank write per word.
module ram_bank_loader #(
  parameter int unsigned ADDR_BIT   = 3,
  parameter int unsigned DATA_BIT   = 16,
  parameter int unsigned MEM_HEIGHT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] base_addr,
  input  logic [ADDR_BIT:0]   length,
  input  logic                in_valid,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                in_ready,
  output logic                en,
  output logic                we,
  output logic                re,
  output logic [ADDR_BIT-1:0] addr_w,
  output logic [DATA_BIT-1:0] d_w,
  output logic                busy,
  output logic                done,
  output logic [ADDR_BIT:0]   count
);

  localparam int unsigned CW = ADDR_BIT + 1;
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [CW-1:0]       DEPTH     = CW'(MEM_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_BIT-1:0] ptr_q, ptr_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [CW-1:0]       count_q, count_d;
  logic                strobe_q, strobe_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                ready_q, busy_q, done_q;

  logic [ADDR_BIT-1:0] base_mod_c;
  logic [CW-1:0]       len_clamp_c;

  assign base_mod_c  = ADDR_BIT'(32'(base_addr) % MEM_HEIGHT);
  assign len_clamp_c = (length > DEPTH) ? DEPTH : length;

  // Next-state, pointer/counter and write-port update
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = base_mod_c;
          rem_d   = len_clamp_c;
          count_d = '0;
          state_d = (len_clamp_c == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          strobe_d = 1'b1;
          addr_d   = ptr_q;
          data_d   = in_data;
          ptr_d    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_BIT'(1);
          count_d  = count_q + CW'(1);
          rem_d    = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      count_q  <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ready_q  <= (state_d == LOAD);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign in_ready = ready_q;
  assign en       = strobe_q;
  assign we       = strobe_q;
  assign re       = 1'b0;
  assign addr_w   = addr_q;
  assign d_w      = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_ram_bank_loader.sv
// Randomized and directed bench for ram_bank_loader against a transaction-level
// model that tracks load target, words taken and the expected write strobe.
module tb_ram_bank_loader;

  localparam int unsigned AB = 3;
  localparam int unsigned DB = 16;
  localparam int unsigned H  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB:0]   length;
  logic          in_valid;
  logic [DB-1:0] in_data;
  logic          in_ready, en, we, re, busy, done;
  logic [AB-1:0] addr_w;
  logic [DB-1:0] d_w;
  logic [AB:0]   count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            m_load, m_done, e_en;
  int            m_base, m_target, m_cnt;
  int            e_addr, e_data;

  ram_bank_loader #(.ADDR_BIT(AB), .DATA_BIT(DB), .MEM_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .en(en), .we(we),
    .re(re), .addr_w(addr_w), .d_w(d_w), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_done = 0; e_en = 0;
    m_base = 0; m_target = 0; m_cnt = 0;
    e_addr = 0; e_data = 0;
  endtask

  // Applies the spec's rules at one rising edge using the inputs present there
  task automatic model_edge();
    e_en = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_load) begin
      if (in_valid) begin
        e_en   = 1;
        e_addr = (m_base + m_cnt) % H;
        e_data = int'(in_data);
        m_cnt++;
        if (m_cnt == m_target) begin
          m_load = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      m_base   = int'(base_addr) % H;
      m_target = (int'(length) > H) ? H : int'(length);
      m_cnt    = 0;
      if (m_target == 0) m_done = 1;
      else               m_load = 1;
    end
  endtask

  task automatic compare();
    chk("in_ready", int'(in_ready), int'(m_load));
    chk("busy",     int'(busy),     int'(m_load | m_done));
    chk("done",     int'(done),     int'(m_done));
    chk("en",       int'(en),       int'(e_en));
    chk("we",       int'(we),       int'(e_en));
    chk("re",       int'(re),       0);
    chk("addr_w",   int'(addr_w),   e_addr);
    chk("d_w",      int'(d_w),      e_data);
    chk("count",    int'(count),    m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic cyc(input bit st, input int b, input int l, input bit v, input int d);
    start     = st;
    base_addr = AB'(b);
    length    = (AB+1)'(l);
    in_valid  = v;
    in_data   = DB'(d);
    tick();
  endtask

  // Start a load then feed data with a given valid probability until it finishes
  task automatic run_load(input int b, input int l, input int pct, input bit noise);
    int guard = 0;
    cyc(1, b, l, 0, 0);
    while ((m_load || m_done) && guard < 200) begin
      bit st;
      st = noise && m_load && ($urandom_range(0, 3) == 0);
      cyc(st, $urandom_range(0, 7), $urandom_range(0, 15),
          $urandom_range(0, 99) < pct, $urandom_range(0, 16'hffff));
      guard++;
    end
    chk("busy_end", int'(busy), 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask

  initial begin
    start = 0; base_addr = '0; length = '0; in_valid = 0; in_data = '0;
    rst = 1'b1;
    model_reset();
    #1 compare();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);

    // Full load, continuous valid, data = address
    cyc(1, 0, 8, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, i);
    cyc(0, 0, 0, 0, 0);
    chk("full_count", int'(count), 8);

    // Wrap-around from base 6
    cyc(1, 6, 4, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 'hA0 + i);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_count", int'(count), 4);

    // Backpressure gaps: valid pattern 1,0,0,1,1
    cyc(1, 2, 3, 0, 0);
    cyc(0, 0, 0, 1, 'h11);
    cyc(0, 0, 0, 0, 'h22);
    cyc(0, 0, 0, 0, 'h33);
    cyc(0, 0, 0, 1, 'h44);
    cyc(0, 0, 0, 1, 'h55);
    cyc(0, 0, 0, 0, 0);

    // Zero length and clamped length
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 3, 12, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 'h100 + i);
    cyc(0, 0, 0, 0, 0);
    chk("clamp_count", int'(count), 8);

    // Start mid-load must be ignored
    cyc(1, 1, 5, 0, 0);
    cyc(0, 0, 0, 1, 'h200);
    cyc(1, 5, 2, 1, 'h201);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 'h202 + i);
    cyc(0, 0, 0, 0, 0);

    // Base beyond depth is not reachable with 8 words and 3 bits; reset mid-load
    cyc(1, 2, 8, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 'h300 + i);
    start = 0; in_valid = 1; in_data = 16'h0303;
    async_reset();
    in_valid = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 5, 3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 'h400 + i);
    cyc(0, 0, 0, 0, 0);

    // Random loads with random backpressure and ignored starts
    for (int n = 0; n < 30; n++) begin
      run_load($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(30, 100), 1'b1);
      for (int k = $urandom_range(0, 2); k > 0; k--) cyc(0, 0, 0, $urandom_range(0, 1), 0);
    end

    // Reset in the middle of a random load
    cyc(1, 4, 8, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 16'hffff));
    start = 0; in_valid = 1;
    async_reset();
    in_valid = 0;
    run_load(7, 6, 70, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bank_loader.md
# ram_bank_loader

Stream-to-RAM write sequencer placed directly upstream of `ram_bank`. On a start command it accepts a programmed number of words from a valid/ready input stream and drives `ram_bank`'s `en`/`we`/`re`/`addr_w`/`d_w` port, one registered write per accepted word, at consecutive addresses from a base with wrap-around. It reports progress (`busy`, `count`) and pulses `done` when the load completes, replacing hand-driven write sequences into the bank.

## Interface
- `ADDR_BIT`, default 3: address width; must match `ram_bank`.
- `DATA_BIT`, default 16: word width; must match `ram_bank`.
- `MEM_HEIGHT`, default 8: bank depth in words; 2 ≤ `MEM_HEIGHT` ≤ 2^`ADDR_BIT`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  load request; sampled only in IDLE.
- `base_addr`  in  `ADDR_BIT`  first write address; sampled with `start`.
- `length`  in  `ADDR_BIT`+1  words to load; sampled with `start`.
- `in_valid`  in  1  input word valid.
- `in_data`  in  `DATA_BIT`  input word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `en`  out  1  to `ram_bank` en.
- `we`  out  1  to `ram_bank` we.
- `re`  out  1  to `ram_bank` re; constant 0.
- `addr_w`  out  `ADDR_BIT`  to `ram_bank` addr_w.
- `d_w`  out  `DATA_BIT`  to `ram_bank` d_w.
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle completion pulse.
- `count`  out  `ADDR_BIT`+1  words accepted in the current or last load.

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE.
- Reset values: all outputs 0; internal address pointer 0; remaining-words counter 0.
- IDLE + `start`=1: latch `base_addr` into the pointer and `min(length, MEM_HEIGHT)` into the remaining counter; clear `count`. If latched length = 0, go to DONE; otherwise go to LOAD.
- `base_addr` ≥ `MEM_HEIGHT` is reduced modulo `MEM_HEIGHT` when latched.
- `in_ready` = 1 exactly while in LOAD. It is decoded from registered state, with no combinational path from `in_valid`.
- Transfer means `in_valid` & `in_ready` at a rising edge. On a transfer:
  - register `d_w` ← `in_data` and `addr_w` ← pointer;
  - set `en` = `we` = 1 for the next cycle;
  - increment the pointer, wrapping `MEM_HEIGHT`-1 → 0;
  - increment `count` and decrement the remaining counter.
- A transfer that brings the remaining counter to 0 moves LOAD → DONE.
- Without a transfer, `en` = `we` = 0 and `addr_w`/`d_w` hold their last values.
- DONE lasts exactly one cycle: `done` = 1, then → IDLE.
- `start` in LOAD or DONE is ignored, with no re-latch.
- `count` holds its final value in IDLE until the next accepted `start`.
- `rst` asserted at any time, including mid-load, forces IDLE and the reset values immediately. A partial load is abandoned, and any write strobe in flight is dropped.

## Timing
- Write latency is 1 cycle: transfer at edge k → `en` = `we` = 1 with matching `addr_w`/`d_w` during cycle k..k+1, so `ram_bank` writes at edge k+1.
- Back-to-back transfers give one write per cycle, so throughput is 1 word/clock.
- `start` at edge s → LOAD (or DONE) from s; `in_ready` is high in the cycle after s.
- The last transfer at edge k puts DONE in cycle k..k+1, coinciding with the final write strobe. IDLE follows from k+1.
- Zero length: `start` at s gives `done` = 1 for cycle s..s+1 with no `en`/`we` pulse.
- The earliest next `start` is accepted at edge k+2, the first edge in IDLE.
- `count` updates at the transfer edge, so it equals the number of transfers already made.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs 0 at once; `in_ready` = 0, `busy` = 0.
- Full load: `base_addr` = 0, `length` = 8, words 0..7 presented with continuous `in_valid` → 8 consecutive cycles of `en` = `we` = 1, `addr_w` 0..7, `d_w` 0..7. `done` is high with the addr 7 strobe and `count` = 8.
- Wrap-around: `base_addr` = 6, `length` = 4, data 0xA0..0xA3 → `addr_w` sequence 6, 7, 0, 1 with matching data; `count` = 4.
- Backpressure gaps: `length` = 3, `in_valid` pattern 1, 0, 0, 1, 1 → strobes only after valid cycles at addresses base, base+1, base+2. No strobe during gaps; `addr_w`/`d_w` hold.
- Length boundaries and ignored start:
  - `length` = 0 → one `done` pulse and no write.
  - `length` = 12 → clamped, exactly 8 writes.
  - `start` with new `base_addr` mid-LOAD → ignored; the sequence continues unchanged.
- Reset mid-load: `rst` after 3 of 8 transfers → `en`/`we`/`busy`/`count` = 0 immediately and no `done`. A new `start` then loads from its own base.
